// File: rtl/imm_encode.sv
// Two-stage valid/ready immediate encoder: classify/check, then pack into template.
// Optional `IMM_ENCODE_ERRCNT_EN adds a saturating error-handshake counter ErrCnt_o.
module imm_encode #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           ImmSrc_i,
    input  logic [DATAWIDTH-1:0] Imm_i,
    input  logic [DATAWIDTH-1:0] Base_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] Instr_o,
    output logic                 Err_o,
`ifdef IMM_ENCODE_ERRCNT_EN
    output logic [1:0]           ErrCode_o,
    output logic [15:0]          ErrCnt_o
`else
    output logic [1:0]           ErrCode_o
`endif
);

    logic                 v1;
    logic [2:0]           s1_src;
    logic [20:0]          s1_imm;
    logic [DATAWIDTH-1:0] s1_base;
    logic [1:0]           s1_code;

    logic s2_adv;
    logic in_hs;

    assign s2_adv     = !out_valid_o || out_ready_i;
    assign in_ready_o = !v1 || s2_adv;
    assign in_hs      = in_valid_i && in_ready_o;

    // Signed-fit tests: all bits above the field's sign bit equal it.
    logic fit12, fit13, fit20, fit21;
    assign fit12 = (&Imm_i[31:11]) || !(|Imm_i[31:11]);
    assign fit13 = (&Imm_i[31:12]) || !(|Imm_i[31:12]);
    assign fit20 = (&Imm_i[31:19]) || !(|Imm_i[31:19]);
    assign fit21 = (&Imm_i[31:20]) || !(|Imm_i[31:20]);

    logic [1:0] code_c;

    always_comb begin
        code_c = 2'b00;
        case (ImmSrc_i)
            3'b000, 3'b001: begin
                if (!fit12) code_c = 2'b01;
            end
            3'b010: begin
                if (Imm_i[0])    code_c = 2'b10;
                else if (!fit13) code_c = 2'b01;
            end
            3'b011: begin
                if (!fit20) code_c = 2'b01;
            end
            3'b100: begin
                if (Imm_i[0])    code_c = 2'b10;
                else if (!fit21) code_c = 2'b01;
            end
            default: code_c = 2'b11;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1      <= 1'b0;
            s1_src  <= 3'b000;
            s1_imm  <= '0;
            s1_base <= '0;
            s1_code <= 2'b00;
        end else begin
            if (in_ready_o) v1 <= in_valid_i;
            if (in_hs) begin
                s1_src  <= ImmSrc_i;
                s1_imm  <= Imm_i[20:0];
                s1_base <= Base_i;
                s1_code <= code_c;
            end
        end
    end

    logic [DATAWIDTH-1:0] mask;
    logic [DATAWIDTH-1:0] fld;
    logic [DATAWIDTH-1:0] packed_c;

    always_comb begin
        mask = '0;
        fld  = '0;
        case (s1_src)
            3'b000: begin
                mask = 32'hFFF0_0000;
                fld  = {s1_imm[11:0], 20'b0};
            end
            3'b001: begin
                mask = 32'hFE00_0F80;
                fld  = {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0};
            end
            3'b010: begin
                mask = 32'hFE00_0F80;
                fld  = {s1_imm[12], s1_imm[10:5], 13'b0,
                        s1_imm[4:1], s1_imm[11], 7'b0};
            end
            3'b011: begin
                mask = 32'hFFFF_F000;
                fld  = {s1_imm[19:0], 12'b0};
            end
            3'b100: begin
                mask = 32'hFFFF_F000;
                fld  = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                        s1_imm[19:12], 12'b0};
            end
            default: begin
                mask = '0;
                fld  = '0;
            end
        endcase
        packed_c = (s1_code == 2'b00) ? ((s1_base & ~mask) | fld) : s1_base;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            Instr_o     <= '0;
            Err_o       <= 1'b0;
            ErrCode_o   <= 2'b00;
        end else if (s2_adv) begin
            out_valid_o <= v1;
            if (v1) begin
                Instr_o   <= packed_c;
                Err_o     <= (s1_code != 2'b00);
                ErrCode_o <= s1_code;
            end
        end
    end

`ifdef IMM_ENCODE_ERRCNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ErrCnt_o <= 16'h0000;
        end else if (out_valid_o && out_ready_i && Err_o
                     && ErrCnt_o != 16'hFFFF) begin
            ErrCnt_o <= ErrCnt_o + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the immediate extender: packs a 32-bit immediate value into RISC-V instruction bit positions for a given ImmSrc format.
- Merges the packed immediate into a caller-supplied instruction template.
- Two-stage valid/ready pipeline: stage 1 classifies and checks the immediate, stage 2 packs it and registers the result.
- Used by the test-program loader/assembler path and the self-check encoder.

Parameters:
DATAWIDTH, 32, instruction and immediate width; only 32 is supported.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when in_valid_i && in_ready_o
ImmSrc_i  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J
Imm_i  in  DATAWIDTH  signed immediate value to encode
Base_i  in  DATAWIDTH  instruction template (opcode/rd/rs/funct fields)
out_valid_o  out  1  output word valid
out_ready_i  in  1  downstream accepts when out_valid_o && out_ready_i
Instr_o  out  DATAWIDTH  encoded instruction
Err_o  out  1  word failed encoding
ErrCode_o  out  2  00 ok, 01 range, 10 misaligned, 11 illegal ImmSrc

Behaviour:
- Reset: asynchronous when rst_n_i low; one clock, rising edge.
  - Both stage valids clear.
  - Reset values: out_valid_o=0, Instr_o=0, Err_o=0, ErrCode_o=0.
  - in_ready_o=1 once empty; it is combinational, so it is 1 during reset.
  - Reset mid-operation drops all in-flight words, with no partial output.
- Handshake:
  - s2_adv = !v2 || out_ready_i.
  - in_ready_o = !v1 || s2_adv.
  - Stage 1 loads on input handshake. Stage 2 loads from stage 1 when v1 && s2_adv.
  - Latency 2 cycles from accept to out_valid_o. Full throughput, 1 word/cycle, when out_ready_i=1.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - No drops, no duplicates; order preserved.
- Range/alignment checks (signed Imm_i):
  - I: -2048..2047.
  - S: -2048..2047.
  - B: -4096..4094, Imm_i[0] must be 0.
  - U: -2^19..2^19-1. Value = sign-extended instr[31:12], unshifted, matching the extender.
  - J: -2^20..2^20-2, Imm_i[0] must be 0.
- Error priority: illegal ImmSrc (101..111) > misaligned > range.
- Packing when the word is ok. Immediate bit positions in Base_i are cleared, then written; all other bits pass through:
  - I: instr[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[19:0].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error words: Instr_o=Base_i unmodified, Err_o=1, ErrCode_o as above. They still flow through the pipeline in order.
- Round-trip invariant: for every ok word, extend(ImmSrc, Instr_o[31:7]) equals Imm_i.

Optional Feature:
IMM_ENCODE_ERRCNT_EN:
- Defined: adds port ErrCnt_o, out, 16 bits.
  - Counts output handshakes with Err_o=1.
  - Saturates at 0xFFFF.
  - Cleared by reset only.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- I, Imm=0xFFFFF800, Base=0x00000013, out_ready_i=1 -> Instr_o=0x80000013, Err_o=0, out_valid_o 2 cycles after accept.
- B, Imm=0x00000FFE, Base=0x00000063 -> Instr_o=0x7E000FE3. Imm=0x00000003 -> Err_o=1, ErrCode_o=10, Instr_o=0x00000063.
- J, Imm=0xFFF00000, Base=0x0000006F -> Instr_o=0x8000006F. Imm=0x00100000 -> ErrCode_o=01. ImmSrc=101 -> ErrCode_o=11.
- U, Imm=0x0007FFFF, Base=0x00000037 -> Instr_o=0x7FFFF037. Imm=0x00080000 -> ErrCode_o=01.
- Backpressure: out_ready_i=0, offer 3 valid words back-to-back:
  - 2 accepted, then in_ready_o=0 while the third is held.
  - After out_ready_i=1, the 3 words emerge in order with no loss or duplication.
  - ErrCnt_o counts only errored handshakes when IMM_ENCODE_ERRCNT_EN is defined.
- Reset mid-stream with both stages full: rst_n_i low asynchronously -> out_valid_o=0 and Instr_o=0 before next clock edge, in_ready_o=1, ErrCnt_o=0.
